// File: rtl/cru_bank_ctrl_if.sv
// rtl/cru_bank_ctrl_if.sv - TI CRU bus and host write port bundle for the CRU bit bank
// The slave side is the bank controller; the master side drives TI pins and the host request.
interface cru_bank_ctrl_if #(
    parameter int NBITS = 8,
    parameter int IDXW  = 4
);
    logic [0:3]       cru_base;
    logic             ti_cru_clk;
    logic             ti_memen;
    logic [0:14]      addr;
    logic             ti_cru_out;
    logic             ti_cru_in;
    logic             host_req;
    logic [NBITS-1:0] host_data;
    logic [NBITS-1:0] host_mask;
    logic             host_ack;
    logic [NBITS-1:0] bits;
    logic             ti_wr_strobe;
    logic [IDXW-1:0]  ti_wr_index;

    modport slave (
        input  cru_base, ti_cru_clk, ti_memen, addr, ti_cru_out,
        input  host_req, host_data, host_mask,
        output ti_cru_in, host_ack, bits, ti_wr_strobe, ti_wr_index
    );

    modport master (
        output cru_base, ti_cru_clk, ti_memen, addr, ti_cru_out,
        output host_req, host_data, host_mask,
        input  ti_cru_in, host_ack, bits, ti_wr_strobe, ti_wr_index
    );
endinterface

// File: rtl/cru_bank_ctrl.sv
// rtl/cru_bank_ctrl.sv - CRU bit bank with TI single-bit writes and arbitrated host masked writes
// TI writes are synchronized, decoded on the CRUCLK edge, then committed from a one-deep pending slot.
module cru_bank_ctrl #(
    parameter int NBITS = 8,
    parameter int IDXW  = 4
) (
    input  logic           clk,
    input  logic           reset,
    cru_bank_ctrl_if.slave bus
);
    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_HOST_WR  = 2'd1;
    localparam logic [1:0] S_ACK_WAIT = 2'd2;

    localparam logic [6:0]       NBITS_W = 7'(NBITS);
    localparam logic [NBITS-1:0] ONE     = {{(NBITS-1){1'b0}}, 1'b1};

    logic             r_s1, r_s2, r_s3;
    logic             r_ti_pend;
    logic             r_pend_dat;
    logic [IDXW-1:0]  r_pend_idx;
    logic [1:0]       r_state;
    logic             r_host_ack;
    logic [NBITS-1:0] r_bits;
    logic [IDXW-1:0]  r_wr_index;

    logic             w_ti_edge;
    logic [6:0]       w_idx;
    logic             w_hit;
    logic             w_commit;
    logic [NBITS-1:0] w_pend_onehot;
    logic [NBITS-1:0] w_rd_onehot;
    logic [NBITS-1:0] w_host_bits;
    logic [1:0]       w_state_nxt;

    assign w_ti_edge = r_s2 & ~r_s3;
    assign w_idx     = bus.addr[8:14];
    assign w_hit     = w_ti_edge & bus.ti_memen & (bus.addr[0:3] == 4'b0001)
                     & (bus.addr[4:7] == bus.cru_base) & (w_idx < NBITS_W);

    // HOST_WR owns the bank for its single cycle; a pending TI bit waits one cycle at most.
    assign w_commit = r_ti_pend & (r_state != S_HOST_WR);

    assign w_pend_onehot = ONE << r_pend_idx;
    assign w_host_bits   = (r_bits & ~bus.host_mask) | (bus.host_data & bus.host_mask);

    // Indices at or above NBITS shift the one-hot out entirely, so they read as 0.
    assign w_rd_onehot = ONE << w_idx;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (bus.host_req && !r_ti_pend && !w_hit) w_state_nxt = S_HOST_WR;
            S_HOST_WR:  w_state_nxt = S_ACK_WAIT;
            S_ACK_WAIT: if (!bus.host_req) w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1       <= 1'b0;
            r_s2       <= 1'b0;
            r_s3       <= 1'b0;
            r_ti_pend  <= 1'b0;
            r_pend_dat <= 1'b0;
            r_pend_idx <= '0;
            r_state    <= S_IDLE;
            r_host_ack <= 1'b0;
            r_bits     <= '0;
            r_wr_index <= '0;
        end else begin
            r_s1    <= bus.ti_cru_clk;
            r_s2    <= r_s1;
            r_s3    <= r_s2;
            r_state <= w_state_nxt;

            // A new hit may coincide with the commit of the previous one; capture wins.
            if (w_hit) begin
                r_ti_pend  <= 1'b1;
                r_pend_idx <= w_idx[IDXW-1:0];
                r_pend_dat <= bus.ti_cru_out;
            end else if (w_commit) begin
                r_ti_pend <= 1'b0;
            end

            if (r_state == S_HOST_WR) begin
                r_bits     <= w_host_bits;
                r_host_ack <= 1'b1;
            end else if (w_commit) begin
                r_bits <= r_pend_dat ? (r_bits | w_pend_onehot) : (r_bits & ~w_pend_onehot);
            end

            if (w_commit) r_wr_index <= r_pend_idx;

            if (r_state == S_ACK_WAIT && !bus.host_req) r_host_ack <= 1'b0;
        end
    end

    assign bus.ti_cru_in    = |(r_bits & w_rd_onehot);
    assign bus.host_ack     = r_host_ack;
    assign bus.bits         = r_bits;
    assign bus.ti_wr_strobe = w_commit;
    assign bus.ti_wr_index  = r_wr_index;
endmodule

// File: tb/tb_cru_bank_ctrl.sv
// tb/tb_cru_bank_ctrl.sv - scoreboard bench for cru_bank_ctrl TI commits, host handshake and read path
module tb_cru_bank_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cru_bank_ctrl_if #(.NBITS(8), .IDXW(4)) bus ();
    cru_bank_ctrl #(.NBITS(8), .IDXW(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        int         cyc;
        int         idx;
        logic [7:0] bits;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       cur;
    logic       chk_pending = 1'b0;
    logic [7:0] exp_bits;
    int         cyc = 0;
    int         n_vec = 0;
    int         n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [14:0] mk_addr(input logic [3:0] g, input logic [3:0] b, input logic [6:0] i);
        return {g, b, i};
    endfunction

    // Raises CRUCLK in the current cycle N; a decoded hit is expected to strobe in N+3.
    task automatic ti_start(input logic [14:0] a, input logic memen, input logic d);
        logic hit;
        bus.addr       = a;
        bus.ti_memen   = memen;
        bus.ti_cru_out = d;
        bus.ti_cru_clk = 1'b1;
        hit = memen && (a[14:11] == 4'h1) && (a[10:7] == bus.cru_base) && (a[6:0] < 7'd8);
        if (hit) begin
            exp_bits[a[2:0]] = d;
            sb_q.push_back('{cyc + 3, int'(a[2:0]), exp_bits});
        end
    endtask

    task automatic ti_write(input logic [14:0] a, input logic memen, input logic d);
        ti_start(a, memen, d);
        repeat (3) tick();
        bus.ti_cru_clk = 1'b0;
        repeat (3) tick();
    endtask

    task automatic host_write(input logic [7:0] d, input logic [7:0] m);
        bus.host_data = d;
        bus.host_mask = m;
        bus.host_req  = 1'b1;
        exp_bits = (exp_bits & ~m) | (d & m);
        tick();
        check("hw_ack_m1", 32'(bus.host_ack), 32'd0);
        tick();
        check("hw_ack_m2", 32'(bus.host_ack), 32'd1);
        check("hw_bits", 32'(bus.bits), 32'(exp_bits));
        repeat (3) begin
            tick();
            check("hw_ack_hold", 32'(bus.host_ack), 32'd1);
        end
        bus.host_req = 1'b0;
        tick();
        check("hw_ack_drop", 32'(bus.host_ack), 32'd0);
        tick();
    endtask

    always @(negedge clk) begin
        if (chk_pending) begin
            check("wr_index", 32'(bus.ti_wr_index), 32'(cur.idx));
            check("wr_bits", 32'(bus.bits), 32'(cur.bits));
            chk_pending <= 1'b0;
        end
        if (!reset && bus.ti_wr_strobe) begin
            if (sb_q.size() == 0) begin
                check("strobe_unexpected", 32'(bus.ti_wr_strobe), 32'd0);
            end else begin
                cur = sb_q.pop_front();
                check("strobe_cycle", 32'(cyc), 32'(cur.cyc));
                chk_pending <= 1'b1;
            end
        end
    end

    initial begin
        reset          = 1'b1;
        bus.cru_base   = 4'h2;
        bus.ti_cru_clk = 1'b0;
        bus.ti_memen   = 1'b1;
        bus.addr       = '0;
        bus.ti_cru_out = 1'b0;
        bus.host_req   = 1'b0;
        bus.host_data  = '0;
        bus.host_mask  = '0;
        exp_bits       = 8'h00;

        repeat (3) tick();
        check("rst_bits", 32'(bus.bits), 32'd0);
        check("rst_ack", 32'(bus.host_ack), 32'd0);
        check("rst_strobe", 32'(bus.ti_wr_strobe), 32'd0);
        check("rst_index", 32'(bus.ti_wr_index), 32'd0);
        reset = 1'b0;
        repeat (2) tick();

        // Basic TI write of bit 0.
        ti_write(mk_addr(4'h1, 4'h2, 7'd0), 1'b1, 1'b1);
        check("ti_first_bits", 32'(bus.bits), 32'h01);

        // Wrong base, out-of-range index, memory cycle: all ignored.
        ti_write(mk_addr(4'h1, 4'h3, 7'd5), 1'b1, 1'b1);
        ti_write(mk_addr(4'h1, 4'h2, 7'd8), 1'b1, 1'b1);
        ti_write(mk_addr(4'h1, 4'h2, 7'd1), 1'b0, 1'b1);
        check("miss_bits", 32'(bus.bits), 32'(exp_bits));

        // Masked host writes.
        host_write(8'hF0, 8'hFF);
        host_write(8'h0F, 8'h3C);
        check("host_cc", 32'(bus.bits), 32'hCC);

        // Host request rises in the TI edge cycle: TI bit 7 commits first.
        ti_start(mk_addr(4'h1, 4'h2, 7'd7), 1'b1, 1'b0);
        tick();
        tick();
        bus.host_data = 8'hFF;
        bus.host_mask = 8'h81;
        bus.host_req  = 1'b1;
        exp_bits = (exp_bits & ~8'h81) | (8'hFF & 8'h81);
        tick();
        check("arb_ack_n3", 32'(bus.host_ack), 32'd0);
        bus.ti_cru_clk = 1'b0;
        tick();
        check("arb_ack_n4", 32'(bus.host_ack), 32'd0);
        tick();
        check("arb_ack_n5", 32'(bus.host_ack), 32'd0);
        tick();
        check("arb_ack_n6", 32'(bus.host_ack), 32'd1);
        check("arb_bits", 32'(bus.bits), 32'hCD);
        bus.host_req = 1'b0;
        tick();
        check("arb_ack_drop", 32'(bus.host_ack), 32'd0);
        repeat (2) tick();

        // TI edge lands in HOST_WR, then a second TI write during ACK_WAIT.
        bus.host_data = 8'h00;
        bus.host_mask = 8'hF0;
        exp_bits = exp_bits & ~8'hF0;
        ti_start(mk_addr(4'h1, 4'h2, 7'd2), 1'b1, 1'b0);
        tick();
        bus.host_req = 1'b1;
        tick();
        check("ov_ack_hostwr", 32'(bus.host_ack), 32'd0);
        tick();
        check("ov_ack_commit", 32'(bus.host_ack), 32'd1);
        bus.ti_cru_clk = 1'b0;
        repeat (2) tick();
        ti_write(mk_addr(4'h1, 4'h2, 7'd6), 1'b1, 1'b1);
        check("ov_ack_held", 32'(bus.host_ack), 32'd1);
        bus.host_req = 1'b0;
        tick();
        check("ov_ack_drop", 32'(bus.host_ack), 32'd0);
        check("ov_bits", 32'(bus.bits), 32'h49);
        tick();

        // Combinational read sweep across and past the bank.
        for (int i = 0; i < 10; i++) begin
            bus.addr = mk_addr(4'h1, 4'h2, 7'(i));
            #1;
            check($sformatf("rd_%0d", i), 32'(bus.ti_cru_in), (i < 8) ? 32'(exp_bits[i[2:0]]) : 32'd0);
        end

        // Reset in the middle of ACK_WAIT.
        bus.host_data = 8'h00;
        bus.host_mask = 8'h00;
        bus.host_req  = 1'b1;
        repeat (3) tick();
        check("mid_ack", 32'(bus.host_ack), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        exp_bits = 8'h00;
        check("mid_rst_ack", 32'(bus.host_ack), 32'd0);
        check("mid_rst_bits", 32'(bus.bits), 32'(exp_bits));
        check("mid_rst_index", 32'(bus.ti_wr_index), 32'd0);
        bus.host_req = 1'b0;
        tick();
        reset = 1'b0;
        repeat (3) tick();
        check("post_rst_ack", 32'(bus.host_ack), 32'd0);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
